// File: rtl/clock_cal_seq_if.sv
// clock_cal_seq_if
// Host-side handshake between the register interface and the calibration sequencer.
//   master : host / register block (drives request, target and abort)
//   slave  : clock_cal_seq (drives ack, result and status flags)
// Signals:
//   cal_req     single-cycle calibration request
//   cal_target  target frequency count, sampled with an accepted cal_req
//   abort       cancel a running calibration or drop an established lock
//   cal_ack     one-cycle pulse, cal_result valid from this cycle
//   cal_result  0 OK, 1 TIMEOUT, 2 RAIL, 3 ABORT
//   cal_busy    calibration in progress
//   locked      loop locked and being monitored
//   lock_lost   one-cycle pulse when a monitored lock is lost
interface clock_cal_seq_if;
  logic        cal_req;
  logic [31:0] cal_target;
  logic        abort;
  logic        cal_ack;
  logic [1:0]  cal_result;
  logic        cal_busy;
  logic        locked;
  logic        lock_lost;

  modport master (
    output cal_req, cal_target, abort,
    input  cal_ack, cal_result, cal_busy, locked, lock_lost
  );

  modport slave (
    input  cal_req, cal_target, abort,
    output cal_ack, cal_result, cal_busy, locked, lock_lost
  );
endinterface

// File: rtl/clock_cal_seq.sv
// clock_cal_seq
// Calibration sequencer for the delay-line clock controller. Accepts a target count from the
// host, holds the controller in reset, releases it, waits for the synchronised lock status to
// stay stable, then reports a result code and monitors the lock for rail excursions.
// Ports:
//   clk          sequencer (ref) clock
//   resetn       asynchronous active-low reset
//   host         clock_cal_seq_if.slave host handshake
//   ctl_resetn   controller reset, active low
//   ctl_counter  controller target count
//   ctl_init     controller init delay (constant INIT_DLY)
//   ctl_status   controller {lock, at_rail, at_top}, asynchronous to clk
module clock_cal_seq #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned SETTLE     = 64,
  parameter logic [31:0] TIMEOUT    = 32'd1000000,
  parameter logic [8:0]  INIT_DLY   = 9'd16
) (
  input  logic                  clk,
  input  logic                  resetn,
  clock_cal_seq_if.slave        host,
  output logic                  ctl_resetn,
  output logic [31:0]           ctl_counter,
  output logic [8:0]            ctl_init,
  input  logic [2:0]            ctl_status
);

  typedef enum logic [2:0] {StIdle, StReset, StWaitLock, StSettle, StLocked} state_e;

  localparam logic [1:0] ResOk      = 2'd0;
  localparam logic [1:0] ResTimeout = 2'd1;
  localparam logic [1:0] ResRail    = 2'd2;
  localparam logic [1:0] ResAbort   = 2'd3;

  localparam logic [31:0] RstLast   = 32'(RST_CYCLES) - 32'd1;
  localparam logic [31:0] SettleCnt = 32'(SETTLE);
  // Timeout counter reads 1 in the first busy cycle, so it is one short of TIMEOUT in the
  // decision cycle and equals TIMEOUT in the cycle the ack is visible.
  localparam logic [31:0] TmoLast   = TIMEOUT - 32'd1;

  state_e      state_q;
  logic [2:0]  sync1_q, sync2_q;
  logic [31:0] tmo_q;
  // Shared by RESET (cycle count), SETTLE (locked-cycle count) and LOCKED (rail-cycle count).
  logic [31:0] phase_q;
  logic        ctl_resetn_q;
  logic [31:0] ctl_counter_q;
  logic        cal_ack_q;
  logic [1:0]  cal_result_q;
  logic        cal_busy_q;
  logic        locked_q;
  logic        lock_lost_q;

  logic        slock, srail, unused_top;
  logic        busy_st;
  logic        do_accept, do_finish, do_lost;
  logic [1:0]  fin_code;

  assign slock      = sync2_q[2];
  assign srail      = sync2_q[1];
  assign unused_top = sync2_q[0];

  // Terminations and accepts, in priority order: abort > timeout > settle-complete > others.
  always_comb begin
    busy_st   = (state_q == StReset) || (state_q == StWaitLock) || (state_q == StSettle);
    do_accept = 1'b0;
    do_finish = 1'b0;
    do_lost   = 1'b0;
    fin_code  = ResOk;
    if ((busy_st || state_q == StLocked) && host.abort) begin
      do_finish = 1'b1;
      fin_code  = ResAbort;
    end else if (busy_st && tmo_q >= TmoLast) begin
      do_finish = 1'b1;
      fin_code  = ResTimeout;
    end else if (state_q == StSettle && slock && phase_q >= SettleCnt) begin
      do_finish = 1'b1;
      fin_code  = srail ? ResRail : ResOk;
    end else if ((state_q == StIdle || state_q == StLocked) && host.cal_req) begin
      do_accept = 1'b1;
    end else if (state_q == StLocked && srail && (phase_q + 32'd1 >= SettleCnt)) begin
      do_lost = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      sync1_q       <= '0;
      sync2_q       <= '0;
      tmo_q         <= '0;
      phase_q       <= '0;
      ctl_resetn_q  <= 1'b0;
      ctl_counter_q <= '0;
      cal_ack_q     <= 1'b0;
      cal_result_q  <= ResOk;
      cal_busy_q    <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      sync1_q     <= ctl_status;
      sync2_q     <= sync1_q;
      cal_ack_q   <= 1'b0;
      lock_lost_q <= 1'b0;

      if (do_accept) begin
        state_q       <= StReset;
        ctl_counter_q <= host.cal_target;
        tmo_q         <= 32'd1;
        phase_q       <= '0;
        ctl_resetn_q  <= 1'b0;
        cal_busy_q    <= 1'b1;
        locked_q      <= 1'b0;
      end else if (do_finish) begin
        cal_ack_q    <= 1'b1;
        cal_result_q <= fin_code;
        cal_busy_q   <= 1'b0;
        phase_q      <= '0;
        if (fin_code == ResOk) begin
          state_q  <= StLocked;
          locked_q <= 1'b1;
        end else begin
          state_q      <= StIdle;
          locked_q     <= 1'b0;
          ctl_resetn_q <= 1'b0;
        end
      end else if (do_lost) begin
        lock_lost_q  <= 1'b1;
        state_q      <= StIdle;
        locked_q     <= 1'b0;
        ctl_resetn_q <= 1'b0;
      end else begin
        if (busy_st && tmo_q != '1) begin
          tmo_q <= tmo_q + 32'd1;
        end
        unique case (state_q)
          StIdle: ;
          StReset: begin
            if (phase_q >= RstLast) begin
              state_q      <= StWaitLock;
              ctl_resetn_q <= 1'b1;
            end else begin
              phase_q <= phase_q + 32'd1;
            end
          end
          StWaitLock: begin
            if (slock) begin
              phase_q <= '0;
              state_q <= StSettle;
            end
          end
          StSettle: begin
            if (!slock) begin
              state_q <= StWaitLock;
            end else begin
              phase_q <= phase_q + 32'd1;
            end
          end
          StLocked: begin
            // Rail counter: consecutive synchronised rail cycles while locked.
            phase_q <= srail ? phase_q + 32'd1 : '0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ctl_resetn      = ctl_resetn_q;
  assign ctl_counter     = ctl_counter_q;
  assign ctl_init        = INIT_DLY;
  assign host.cal_ack    = cal_ack_q;
  assign host.cal_result = cal_result_q;
  assign host.cal_busy   = cal_busy_q;
  assign host.locked     = locked_q;
  assign host.lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_clock_cal_seq.sv
// tb_clock_cal_seq
// Directed sequence with randomised targets and lock-flicker positions. Expected ack cycles are
// derived from a per-cycle plan of the controller lock/rail inputs: the synchronised lock at
// cycle c is the driven lock at c-2, and an OK result needs an unbroken run of SET+2 locked
// synchronised cycles starting no earlier than the first cycle the controller is out of reset.
module tb_clock_cal_seq;
  localparam int          RST  = 4;
  localparam int          SET  = 8;
  localparam int          TMO  = 200;
  localparam logic [8:0]  INIT = 9'd37;
  localparam int          PLEN = 4096;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ctl_resetn;
  logic [31:0] ctl_counter;
  logic [8:0]  ctl_init;
  logic [2:0]  ctl_status;

  clock_cal_seq_if host ();

  clock_cal_seq #(
    .RST_CYCLES(RST),
    .SETTLE    (SET),
    .TIMEOUT   (32'(TMO)),
    .INIT_DLY  (INIT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .host       (host),
    .ctl_resetn (ctl_resetn),
    .ctl_counter(ctl_counter),
    .ctl_init   (ctl_init),
    .ctl_status (ctl_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit plan_lock[PLEN];
  bit plan_rail[PLEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs read afterwards belong to cycle 'cyc'.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (cyc >= PLEN - 1) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, PLEN - 1);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
    ctl_status = {plan_lock[cyc], plan_rail[cyc], 1'($urandom)};
  endtask

  task automatic set_plan(input int from, input bit lk, input bit rl);
    for (int c = from; c < PLEN; c++) begin
      plan_lock[c] = lk;
      plan_rail[c] = rl;
    end
  endtask

  function automatic bit slk(input int c);
    return (c >= 2) ? plan_lock[c - 2] : 1'b0;
  endfunction

  // Ack cycle of an OK/RAIL completion when the controller leaves reset at cycle w.
  function automatic int mdl_ack(input int w);
    for (int t = w; t + SET + 2 < PLEN; t++) begin
      bit ok;
      ok = 1'b1;
      for (int j = 0; j <= SET + 1; j++) if (!slk(t + j)) ok = 1'b0;
      if (ok) return t + SET + 2;
    end
    return PLEN;
  endfunction

  task automatic accept(input logic [31:0] tgt, output int n);
    n = cyc;
    host.cal_req    = 1'b1;
    host.cal_target = tgt;
    step();
    host.cal_req    = 1'b0;
    host.cal_target = $urandom;
  endtask

  task automatic wait_ack(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (host.cal_ack === 1'b1) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  initial begin
    int n, at, ex, c, lost_at, lost_cnt, ack_cnt, m;
    logic [31:0] tgt;

    host.cal_req    = 1'b0;
    host.cal_target = '0;
    host.abort      = 1'b0;
    set_plan(0, 1'b1, 1'b0);
    ctl_status = 3'b100;
    #2;
    chk("rst_ctl_resetn", 32'(ctl_resetn), 0);
    chk("rst_ctl_counter", ctl_counter, 0);
    chk("rst_ctl_init", 32'(ctl_init), 32'(INIT));
    chk("rst_cal_ack", 32'(host.cal_ack), 0);
    chk("rst_cal_result", 32'(host.cal_result), 0);
    chk("rst_cal_busy", 32'(host.cal_busy), 0);
    chk("rst_locked", 32'(host.locked), 0);
    chk("rst_lock_lost", 32'(host.lock_lost), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) step();

    // Basic lock with a busy-time request that must be ignored.
    tgt = $urandom;
    accept(tgt, n);
    chk("acc_busy", 32'(host.cal_busy), 1);
    chk("acc_ctl_resetn", 32'(ctl_resetn), 0);
    chk("acc_counter", ctl_counter, tgt);
    for (int k = 2; k <= RST; k++) begin
      step();
      host.cal_req = 1'b0;
      chk("rst_hold_low", 32'(ctl_resetn), 0);
      if (k == 2) begin
        host.cal_req    = 1'b1;
        host.cal_target = ~tgt;
      end
    end
    host.cal_req = 1'b0;
    step();
    chk("rst_release", 32'(ctl_resetn), 1);
    chk("busy_req_ignored", ctl_counter, tgt);
    wait_ack(100, at);
    chk("ok_ack_cycle", 32'(at), 32'(n + RST + 3 + SET));
    chk("ok_result", 32'(host.cal_result), 0);
    chk("ok_locked", 32'(host.locked), 1);
    chk("ok_busy", 32'(host.cal_busy), 0);
    chk("ok_ctl_resetn", 32'(ctl_resetn), 1);
    step();
    chk("ok_ack_pulse", 32'(host.cal_ack), 0);

    // Rail while locked: single lock_lost pulse, no ack.
    c = cyc + 1;
    set_plan(c, 1'b1, 1'b1);
    lost_at = -1; lost_cnt = 0; ack_cnt = 0;
    while (cyc < c + SET + 6) begin
      step();
      if (host.lock_lost === 1'b1) begin
        lost_cnt++;
        if (lost_at < 0) lost_at = cyc;
      end
      if (host.cal_ack === 1'b1) ack_cnt++;
    end
    chk("lost_cycle", 32'(lost_at), 32'(c + 2 + SET));
    chk("lost_pulses", 32'(lost_cnt), 1);
    chk("lost_no_ack", 32'(ack_cnt), 0);
    chk("lost_locked", 32'(host.locked), 0);
    chk("lost_ctl_resetn", 32'(ctl_resetn), 0);
    chk("lost_result_held", 32'(host.cal_result), 0);

    // Abort with request in IDLE: accepted, abort ignored; then abort while busy.
    set_plan(cyc + 1, 1'b1, 1'b0);
    tgt = $urandom;
    host.abort = 1'b1;
    accept(tgt, n);
    host.abort = 1'b0;
    chk("idle_abort_busy", 32'(host.cal_busy), 1);
    chk("idle_abort_counter", ctl_counter, tgt);
    chk("idle_abort_no_ack", 32'(host.cal_ack), 0);
    m = n + $urandom_range(2, RST + 6);
    while (cyc < m) step();
    host.abort = 1'b1;
    step();
    host.abort = 1'b0;
    chk("abort_ack", 32'(host.cal_ack), 1);
    chk("abort_result", 32'(host.cal_result), 3);
    chk("abort_ctl_resetn", 32'(ctl_resetn), 0);
    chk("abort_busy", 32'(host.cal_busy), 0);

    // Rail at settle completion.
    set_plan(cyc + 1, 1'b1, 1'b1);
    repeat (3) step();
    accept($urandom, n);
    ex = mdl_ack(n + RST + 1);
    wait_ack(100, at);
    chk("rail_ack_cycle", 32'(at), 32'(ex));
    chk("rail_result", 32'(host.cal_result), 2);
    chk("rail_ctl_resetn", 32'(ctl_resetn), 0);
    chk("rail_locked", 32'(host.locked), 0);

    // Lock flicker at random positions around the settle window.
    for (int it = 0; it < 3; it++) begin
      set_plan(cyc + 1, 1'b1, 1'b0);
      repeat (3) step();
      accept($urandom, n);
      plan_lock[n + RST + 1 + $urandom_range(0, SET + 2)] = 1'b0;
      ex = mdl_ack(n + RST + 1);
      wait_ack(100, at);
      chk("flicker_ack_cycle", 32'(at), 32'(ex));
      chk("flicker_result", 32'(host.cal_result), 0);
      chk("flicker_locked", 32'(host.locked), 1);
    end
    host.abort = 1'b1;
    step();
    host.abort = 1'b0;
    chk("locked_abort_ack", 32'(host.cal_ack), 1);
    chk("locked_abort_result", 32'(host.cal_result), 3);
    chk("locked_abort_locked", 32'(host.locked), 0);
    chk("locked_abort_ctl_resetn", 32'(ctl_resetn), 0);

    // Timeout with lock never asserted.
    set_plan(cyc + 1, 1'b0, 1'b0);
    repeat (3) step();
    accept($urandom, n);
    wait_ack(TMO + 20, at);
    chk("tmo_ack_cycle", 32'(at), 32'(n + TMO));
    chk("tmo_result", 32'(host.cal_result), 1);
    chk("tmo_ctl_resetn", 32'(ctl_resetn), 0);
    chk("tmo_locked", 32'(host.locked), 0);
    chk("tmo_busy", 32'(host.cal_busy), 0);

    // Abort in the same decision cycle as the timeout.
    accept($urandom, n);
    ack_cnt = 0;
    while (cyc < n + TMO - 1) begin
      step();
      if (host.cal_ack === 1'b1) ack_cnt++;
    end
    chk("tmo_abort_no_early_ack", 32'(ack_cnt), 0);
    host.abort = 1'b1;
    step();
    host.abort = 1'b0;
    chk("tmo_abort_ack", 32'(host.cal_ack), 1);
    chk("tmo_abort_result", 32'(host.cal_result), 3);

    // Asynchronous reset mid-calibration.
    set_plan(cyc + 1, 1'b1, 1'b0);
    tgt = $urandom | 32'h1;
    accept(tgt, n);
    repeat (RST + 2) step();
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_busy", 32'(host.cal_busy), 0);
    chk("areset_ctl_resetn", 32'(ctl_resetn), 0);
    chk("areset_counter", ctl_counter, 0);
    chk("areset_ack", 32'(host.cal_ack), 0);
    @(negedge clk);
    resetn = 1'b1;
    ack_cnt = 0;
    repeat (SET + 8) begin
      step();
      if (host.cal_ack === 1'b1) ack_cnt++;
    end
    chk("areset_no_ack", 32'(ack_cnt), 0);
    chk("areset_idle", 32'(host.cal_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
